jtdsp16_do_cache: RTL and testbench



---
 rtl/jtdsp16_pkg.sv | 30 +++
 rtl/jtdsp16_do_cache_if.sv | 37 +++
 rtl/jtdsp16_cache_mem.sv | 43 ++++
 rtl/jtdsp16_do_cache.sv | 148 ++++++++++++++
 tb/tb_jtdsp16_do_cache.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared constants, state encoding and the do/redo command layout for the DSP16 loop cache.
package jtdsp16_pkg;

  localparam int unsigned DEPTH    = 15;
  localparam int unsigned KW       = 7;
  localparam int unsigned PTR_W    = 4;
  localparam int unsigned DW       = 16;
  localparam int unsigned DO_W     = 11;
  localparam int unsigned DO_N_MSB = 10;
  localparam int unsigned DO_N_LSB = 7;
  localparam int unsigned DO_K_MSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  // do_data word: N=0 means redo
  typedef struct packed {
    logic [DO_N_MSB-DO_N_LSB:0] n;
    logic [DO_K_MSB:0]          k;
  } do_cmd_t;

  // Pass-count decrement that holds at zero
  function automatic logic [KW-1:0] dec_sat(input logic [KW-1:0] v);
    return (v != '0) ? v - KW'(1) : '0;
  endfunction

endpackage

// File: rtl/jtdsp16_do_cache_if.sv
// Decoder/fetch-side bus of the loop cache. cstate exists only with JTDSP16_CACHE_CSTATE_EN.
interface jtdsp16_do_cache_if;
  import jtdsp16_pkg::*;

  logic            cen;
  logic            do_start;
  logic [DO_W-1:0] do_data;
  logic            fetch_adv;
  logic [DW-1:0]   rom_dout;
  logic [DW-1:0]   cache_dout;
  logic            cache_sel;
  logic            pc_hold;
  logic            busy;
  logic            redo_err;
`ifdef JTDSP16_CACHE_CSTATE_EN
  logic [15:0]     cstate;

  modport slave (
    input  cen, do_start, do_data, fetch_adv, rom_dout,
    output cache_dout, cache_sel, pc_hold, busy, redo_err, cstate
  );
  modport master (
    output cen, do_start, do_data, fetch_adv, rom_dout,
    input  cache_dout, cache_sel, pc_hold, busy, redo_err, cstate
  );
`else
  modport slave (
    input  cen, do_start, do_data, fetch_adv, rom_dout,
    output cache_dout, cache_sel, pc_hold, busy, redo_err
  );
  modport master (
    output cen, do_start, do_data, fetch_adv, rom_dout,
    input  cache_dout, cache_sel, pc_hold, busy, redo_err
  );
`endif

endinterface

// File: rtl/jtdsp16_cache_mem.sv
// 15x16 loop-body register file: one write port, one registered read port with write bypass.
module jtdsp16_cache_mem
  import jtdsp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             re,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (we && (wr_addr < PTR_W'(DEPTH))) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A one-word loop reads entry 0 on the same edge it is written
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (we && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (re) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/jtdsp16_do_cache.sv
// DSP16 do/redo loop cache: captures the loop body on first fetch, then replays it with the PC frozen.
// Optional debug/save output cstate is built when JTDSP16_CACHE_CSTATE_EN is defined.
module jtdsp16_do_cache
  import jtdsp16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  jtdsp16_do_cache_if.slave  bus
);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] n_len_q, n_len_d;
  logic [KW-1:0]    iter_q, iter_d;
  logic             cache_valid_q, cache_valid_d;
  logic             cache_sel_q, cache_sel_d;
  logic             pc_hold_q, pc_hold_d;
  logic             busy_q, busy_d;
  logic             redo_err_q, redo_err_d;

  do_cmd_t          cmd;
  logic             mem_we;
  logic [PTR_W-1:0] last_idx;
  logic [PTR_W-1:0] last_idx_d;
  logic [KW-1:0]    iter_dec;

  assign cmd        = do_cmd_t'(bus.do_data);
  assign last_idx   = n_len_q - PTR_W'(1);
  assign last_idx_d = n_len_d - PTR_W'(1);
  assign iter_dec   = dec_sat(iter_q);

  // Loop control and registered outputs; iter counts passes still to be issued
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    n_len_d       = n_len_q;
    iter_d        = iter_q;
    cache_valid_d = cache_valid_q;
    redo_err_d    = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.do_start) begin
          if (cmd.n != '0) begin
            n_len_d       = cmd.n;
            iter_d        = cmd.k;
            cache_valid_d = 1'b0;
            wr_ptr_d      = '0;
            state_d       = ST_FILL;
          end else if (cache_valid_q) begin
            iter_d   = cmd.k;
            rd_ptr_d = '0;
            state_d  = ST_REPLAY;
          end else begin
            redo_err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (bus.fetch_adv) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == last_idx) begin
            cache_valid_d = 1'b1;
            iter_d        = iter_dec;
            if (iter_dec == '0) begin
              state_d = ST_IDLE;
            end else begin
              rd_ptr_d = '0;
              state_d  = ST_REPLAY;
            end
          end
        end
      end
      ST_REPLAY: begin
        if (rd_ptr_q == last_idx) begin
          rd_ptr_d = '0;
          iter_d   = iter_dec;
          if (iter_q <= KW'(1)) begin
            state_d = ST_IDLE;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cache_sel_d = (state_d == ST_REPLAY);
    // Release the PC while the final word of the final pass is on cache_dout
    pc_hold_d   = (state_d == ST_REPLAY) &&
                  !((rd_ptr_d == last_idx_d) && (iter_d <= KW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      n_len_q       <= '0;
      iter_q        <= '0;
      cache_valid_q <= 1'b0;
      cache_sel_q   <= 1'b0;
      pc_hold_q     <= 1'b0;
      busy_q        <= 1'b0;
      redo_err_q    <= 1'b0;
    end else if (bus.cen) begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      n_len_q       <= n_len_d;
      iter_q        <= iter_d;
      cache_valid_q <= cache_valid_d;
      cache_sel_q   <= cache_sel_d;
      pc_hold_q     <= pc_hold_d;
      busy_q        <= busy_d;
      redo_err_q    <= redo_err_d;
    end
  end

  // Read address is the next pointer so cache_dout lines up with cache_sel
  jtdsp16_cache_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.cen & mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.rom_dout),
    .re      (bus.cen & (state_d == ST_REPLAY)),
    .rd_addr (rd_ptr_d),
    .rd_data (bus.cache_dout)
  );

  assign bus.cache_sel = cache_sel_q;
  assign bus.pc_hold   = pc_hold_q;
  assign bus.busy      = busy_q;
  assign bus.redo_err  = redo_err_q;

`ifdef JTDSP16_CACHE_CSTATE_EN
  assign bus.cstate = {1'b0, iter_q, n_len_q, rd_ptr_q};
`endif

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Directed self-checking bench for the DSP16 do/redo loop cache.
module tb_jtdsp16_do_cache;
  import jtdsp16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] exp_w [16];

  jtdsp16_do_cache_if bus ();

  jtdsp16_do_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] n, input logic [6:0] k);
    bus.do_start = 1'b1;
    bus.do_data  = {n, k};
    tick();
    bus.do_start = 1'b0;
    bus.do_data  = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"},  32'(bus.cache_sel), 32'd0);
    check({tag, "_hold"}, 32'(bus.pc_hold),   32'd0);
    check({tag, "_busy"}, 32'(bus.busy),      32'd0);
    check({tag, "_err"},  32'(bus.redo_err),  32'd0);
    check({tag, "_dout"}, 32'(bus.cache_dout), 32'd0);
  endtask

  // Feed n loop words from exp_w; fill cycles stall_a/stall_b (1-based) have fetch_adv low
  task automatic fill(input int n, input int stall_a, input int stall_b);
    int c = 0;
    int w = 0;
    while (w < n) begin
      c++;
      if (c == stall_a || c == stall_b) begin
        bus.fetch_adv = 1'b0;
        bus.rom_dout  = 16'hdead;
      end else begin
        bus.fetch_adv = 1'b1;
        bus.rom_dout  = exp_w[w];
        w++;
      end
      tick();
      if (w < n) begin
        check("fill_sel",  32'(bus.cache_sel), 32'd0);
        check("fill_hold", 32'(bus.pc_hold),   32'd0);
        check("fill_busy", 32'(bus.busy),      32'd1);
      end
    end
    bus.fetch_adv = 1'b0;
    bus.rom_dout  = 16'h0;
  endtask

  // Expect n*passes replay cycles of exp_w, optionally with a cen freeze and an illegal nested do
  task automatic run_replay(input int n, input int passes, input int nest_at, input int freeze_at);
    int total = n * passes;
    for (int i = 0; i < total; i++) begin
      check("rp_sel",  32'(bus.cache_sel),  32'd1);
      check("rp_dout", 32'(bus.cache_dout), 32'(exp_w[i % n]));
      check("rp_hold", 32'(bus.pc_hold),    32'(i != total - 1));
      check("rp_busy", 32'(bus.busy),       32'd1);
      if (i == freeze_at) begin
        bus.cen = 1'b0;
        tick();
        check("frz_dout", 32'(bus.cache_dout), 32'(exp_w[i % n]));
        check("frz_hold", 32'(bus.pc_hold),    32'(i != total - 1));
        bus.cen = 1'b1;
      end
      if (i == nest_at) begin
        bus.do_start = 1'b1;
        bus.do_data  = {4'd2, 7'd5};
      end
      tick();
      bus.do_start = 1'b0;
      bus.do_data  = '0;
    end
    check("rp_end_sel",  32'(bus.cache_sel), 32'd0);
    check("rp_end_hold", 32'(bus.pc_hold),   32'd0);
    check("rp_end_busy", 32'(bus.busy),      32'd0);
  endtask

  initial begin
    bus.cen       = 1'b1;
    bus.do_start  = 1'b0;
    bus.do_data   = '0;
    bus.fetch_adv = 1'b0;
    bus.rom_dout  = '0;
    rst_n         = 1'b0;
    #12;
    check_zero("rst");
`ifdef JTDSP16_CACHE_CSTATE_EN
    check("rst_cstate", 32'(bus.cstate), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // do N=3 K=4: fill A,B,C then three replay passes
    exp_w[0] = 16'haaaa; exp_w[1] = 16'hbbbb; exp_w[2] = 16'hcccc;
    issue(4'd3, 7'd4);
    check("do3_busy", 32'(bus.busy), 32'd1);
    check("do3_sel",  32'(bus.cache_sel), 32'd0);
    fill(3, 0, 0);
`ifdef JTDSP16_CACHE_CSTATE_EN
    check("do3_cstate", 32'(bus.cstate), 32'h0330);
`endif
    run_replay(3, 3, 4, 5);

    // do N=2 K=1: single pass, no replay
    exp_w[0] = 16'h1234; exp_w[1] = 16'h5678;
    issue(4'd2, 7'd1);
    fill(2, 0, 0);
    check("do2_sel",  32'(bus.cache_sel), 32'd0);
    check("do2_busy", 32'(bus.busy),      32'd0);
    tick();
    check("do2_idle_sel", 32'(bus.cache_sel), 32'd0);

    // redo K=3 with junk on ROM, then redo K=1 to confirm nothing was overwritten
    bus.fetch_adv = 1'b1;
    bus.rom_dout  = 16'hbeef;
    issue(4'd0, 7'd3);
    run_replay(2, 3, -1, -1);
    bus.fetch_adv = 1'b0;
    issue(4'd0, 7'd1);
    run_replay(2, 1, -1, -1);

    // do N=1 K=2: replay word read on the same edge it is written
    exp_w[0] = 16'h5a5a;
    issue(4'd1, 7'd2);
    fill(1, 0, 0);
    run_replay(1, 1, -1, -1);

    // reset clears cache_valid, so redo errors
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    issue(4'd0, 7'd5);
    check("rerr_err",  32'(bus.redo_err),  32'd1);
    check("rerr_busy", 32'(bus.busy),      32'd0);
    check("rerr_sel",  32'(bus.cache_sel), 32'd0);
    tick();
    check("rerr_pulse", 32'(bus.redo_err), 32'd0);

    // do N=15 K=2 with fill stalls on cycles 3 and 7
    for (int w = 0; w < 15; w++) exp_w[w] = 16'(16'h1000 + 16'(w) * 16'h0111);
    issue(4'd15, 7'd2);
    fill(15, 3, 7);
    run_replay(15, 1, -1, -1);

    // do N=4 K=3, reset during the fourth replay cycle
    for (int w = 0; w < 4; w++) exp_w[w] = 16'(16'hc000 + 16'(w));
    issue(4'd4, 7'd3);
    fill(4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("mr_dout", 32'(bus.cache_dout), 32'(exp_w[i]));
      tick();
    end
    check("mr_dout3", 32'(bus.cache_dout), 32'(exp_w[3]));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mrst");
    rst_n = 1'b1;
    issue(4'd0, 7'd3);
    check("mr_err",  32'(bus.redo_err),  32'd1);
    check("mr_busy", 32'(bus.busy),      32'd0);
    check("mr_sel",  32'(bus.cache_sel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
